// File: rtl/z8086_pkg.sv
// Shared types, opcode constants and helpers for the z8086 core.
package z8086_pkg;

    typedef enum logic [2:0] {
        ST_FETCH_OP,
        ST_FETCH_IMM,
        ST_EXEC,
        ST_BUS_WR,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        R_AX, R_CX, R_DX, R_BX, R_SP, R_BP, R_SI, R_DI
    } reg_idx_t;

    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_INC,
        ALU_DEC
    } alu_op_t;

    localparam logic [7:0] OP_NOP      = 8'h90;
    localparam logic [7:0] OP_HLT      = 8'hF4;
    localparam logic [7:0] OP_ADD_AX   = 8'h05;
    localparam logic [7:0] OP_JMP8     = 8'hEB;
    localparam logic [7:0] OP_STORE_AX = 8'hA3;
    localparam logic [7:0] OP_OUT_AX   = 8'hE7;
    localparam logic [4:0] OP_MOV_R8   = 5'b10110;  // B0-B7
    localparam logic [4:0] OP_MOV_R16  = 5'b10111;  // B8-BF
    localparam logic [3:0] OP_INCDEC   = 4'h4;      // 40-4F

    localparam int FLAG_CF = 0;
    localparam int FLAG_ZF = 6;
    localparam int FLAG_SF = 7;
    localparam int FLAG_OF = 11;
    localparam logic [15:0] FLAGS_RESET = 16'h0002;

    function automatic logic [19:0] phys_addr(input logic [15:0] seg, input logic [15:0] off);
        return {seg, 4'b0000} + {4'b0000, off};
    endfunction

    // Number of immediate bytes that follow each opcode.
    function automatic logic [1:0] imm_bytes(input logic [7:0] op);
        logic [1:0] n;
        n = 2'd0;
        if (op[7:3] == OP_MOV_R8)
            n = 2'd1;
        else if (op[7:3] == OP_MOV_R16)
            n = 2'd2;
        else if (op == OP_ADD_AX || op == OP_STORE_AX)
            n = 2'd2;
        else if (op == OP_JMP8 || op == OP_OUT_AX)
            n = 2'd1;
        return n;
    endfunction

endpackage

// File: rtl/z8086_alu.sv
// 16-bit add / increment / decrement with CF, ZF, SF and OF outputs.
module z8086_alu
    import z8086_pkg::*;
(
    input  alu_op_t     op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] res,
    output logic        cf,
    output logic        zf,
    output logic        sf,
    output logic        of
);

    logic [16:0] sum;

    always_comb begin
        sum = 17'd0;
        of  = 1'b0;
        case (op)
            ALU_INC: begin
                sum = {1'b0, a} + 17'd1;
                of  = (a == 16'h7FFF);
            end
            ALU_DEC: begin
                sum = {1'b0, a} - 17'd1;
                of  = (a == 16'h8000);
            end
            default: begin
                sum = {1'b0, a} + {1'b0, b};
                of  = (a[15] == b[15]) && (sum[15] != a[15]);
            end
        endcase
        res = sum[15:0];
        cf  = sum[16];
        zf  = (sum[15:0] == 16'h0000);
        sf  = sum[15];
    end

endmodule

// File: rtl/z8086_cpu.sv
// Minimal 8086-subset core: byte fetch from CS:IP, small opcode set, single-master bus.
// Optional debug build: define Z8086_DBG_EN for dbg_first_done and bus_pending.
module z8086_cpu
    import z8086_pkg::*;
#(
    parameter logic [15:0] RESET_CS = 16'hF000,
    parameter logic [15:0] RESET_IP = 16'hFFF0
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [19:0] addr,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        wr,
    output logic        rd,
    output logic        io,
    output logic        word,
    input  logic        ready,
    input  logic        intr,
    input  logic        nmi,
`ifdef Z8086_DBG_EN
    output logic        dbg_first_done,
`endif
    output logic        inta
);

    // Bus handshake: rd/wr pulse for one cycle and start a transfer; addr, io,
    // word and dout stay put until ready, which is only honoured after the strobe.
    logic [15:0] AX, CX, DX, BX, SP, BP, SI, DI;
    logic [15:0] CS, DS, ES, SS, IP, F;
    logic        not_halted;

    state_t      state, state_next;
    logic        busy;
    logic [7:0]  opcode;
    logic [15:0] imm;
    logic [1:0]  imm_cnt, imm_need;
    logic        accept, issue_rd, issue_wr, exec_done, is_write_op;

    logic        reg_we;
    reg_idx_t    reg_sel;
    logic [15:0] reg_val, r16_cur, r8_cur;
    logic        flags_we;

    alu_op_t     alu_op;
    logic [15:0] alu_a, alu_res;
    logic        alu_cf, alu_zf, alu_sf, alu_of;

    logic        unused_inputs;
    assign unused_inputs = ^{din[15:8], intr, nmi};
    assign inta          = 1'b0;

    assign accept      = busy && ready && !rd && !wr;
    assign is_write_op = (opcode == OP_STORE_AX) || (opcode == OP_OUT_AX);

    always_comb begin
        state_next = state;
        issue_rd   = 1'b0;
        issue_wr   = 1'b0;
        exec_done  = 1'b0;
        case (state)
            ST_FETCH_OP: begin
                if (!busy)
                    issue_rd = 1'b1;
                else if (accept)
                    state_next = (imm_bytes(din[7:0]) == 2'd0) ? ST_EXEC : ST_FETCH_IMM;
            end
            ST_FETCH_IMM: begin
                if (!busy)
                    issue_rd = 1'b1;
                else if (accept && (imm_cnt + 2'd1 == imm_need))
                    state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (opcode == OP_HLT) begin
                    state_next = ST_HALT;
                    exec_done  = 1'b1;
                end else if (is_write_op) begin
                    state_next = ST_BUS_WR;
                end else begin
                    state_next = ST_FETCH_OP;
                    exec_done  = 1'b1;
                end
            end
            ST_BUS_WR: begin
                if (!busy)
                    issue_wr = 1'b1;
                else if (accept) begin
                    state_next = ST_FETCH_OP;
                    exec_done  = 1'b1;
                end
            end
            default: state_next = ST_HALT;
        endcase
    end

    always_comb begin
        case (reg_idx_t'(opcode[2:0]))
            R_AX:    r16_cur = AX;
            R_CX:    r16_cur = CX;
            R_DX:    r16_cur = DX;
            R_BX:    r16_cur = BX;
            R_SP:    r16_cur = SP;
            R_BP:    r16_cur = BP;
            R_SI:    r16_cur = SI;
            default: r16_cur = DI;
        endcase
        case (opcode[1:0])
            2'd0:    r8_cur = AX;
            2'd1:    r8_cur = CX;
            2'd2:    r8_cur = DX;
            default: r8_cur = BX;
        endcase
    end

    always_comb begin
        alu_op = ALU_ADD;
        alu_a  = AX;
        if (opcode[7:4] == OP_INCDEC) begin
            alu_op = opcode[3] ? ALU_DEC : ALU_INC;
            alu_a  = r16_cur;
        end
    end

    z8086_alu u_alu (
        .op  (alu_op),
        .a   (alu_a),
        .b   (imm),
        .res (alu_res),
        .cf  (alu_cf),
        .zf  (alu_zf),
        .sf  (alu_sf),
        .of  (alu_of)
    );

    // Byte moves hit AL..BL for B0-B3 and AH..BH for B4-B7.
    always_comb begin
        reg_we   = 1'b0;
        reg_sel  = reg_idx_t'(opcode[2:0]);
        reg_val  = alu_res;
        flags_we = 1'b0;
        if (state == ST_EXEC) begin
            if (opcode[7:3] == OP_MOV_R8) begin
                reg_we  = 1'b1;
                reg_sel = reg_idx_t'({1'b0, opcode[1:0]});
                reg_val = opcode[2] ? {imm[7:0], r8_cur[7:0]} : {r8_cur[15:8], imm[7:0]};
            end else if (opcode[7:3] == OP_MOV_R16) begin
                reg_we  = 1'b1;
                reg_val = imm;
            end else if (opcode[7:4] == OP_INCDEC) begin
                reg_we   = 1'b1;
                flags_we = 1'b1;
            end else if (opcode == OP_ADD_AX) begin
                reg_we   = 1'b1;
                reg_sel  = R_AX;
                flags_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state      <= ST_FETCH_OP;
            {AX, CX, DX, BX, SP, BP, SI, DI} <= '0;
            CS         <= RESET_CS;
            DS         <= 16'h0000;
            ES         <= 16'h0000;
            SS         <= 16'h0000;
            IP         <= RESET_IP;
            F          <= FLAGS_RESET;
            not_halted <= 1'b1;
            busy       <= 1'b0;
            rd         <= 1'b0;
            wr         <= 1'b0;
            io         <= 1'b0;
            word       <= 1'b0;
            addr       <= 20'h00000;
            dout       <= 16'h0000;
            opcode     <= 8'h00;
            imm        <= 16'h0000;
            imm_cnt    <= 2'd0;
            imm_need   <= 2'd0;
        end else begin
            state <= state_next;
            rd    <= issue_rd;
            wr    <= issue_wr;
            if (accept)
                busy <= 1'b0;
            if (issue_rd) begin
                busy <= 1'b1;
                addr <= phys_addr(CS, IP);
                io   <= 1'b0;
                word <= 1'b0;
            end
            if (issue_wr) begin
                busy <= 1'b1;
                word <= 1'b1;
                dout <= AX;
                io   <= (opcode == OP_OUT_AX);
                addr <= (opcode == OP_OUT_AX) ? {12'h000, imm[7:0]} : phys_addr(DS, imm);
            end
            if (accept && state == ST_FETCH_OP) begin
                opcode   <= din[7:0];
                IP       <= IP + 16'd1;
                imm      <= 16'h0000;
                imm_cnt  <= 2'd0;
                imm_need <= imm_bytes(din[7:0]);
            end
            if (accept && state == ST_FETCH_IMM) begin
                IP      <= IP + 16'd1;
                imm_cnt <= imm_cnt + 2'd1;
                if (imm_cnt == 2'd0)
                    imm[7:0] <= din[7:0];
                else
                    imm[15:8] <= din[7:0];
            end
            if (state == ST_EXEC && opcode == OP_JMP8)
                IP <= IP + {{8{imm[7]}}, imm[7:0]};
            if (state == ST_EXEC && opcode == OP_HLT)
                not_halted <= 1'b0;
            if (reg_we) begin
                case (reg_sel)
                    R_AX:    AX <= reg_val;
                    R_CX:    CX <= reg_val;
                    R_DX:    DX <= reg_val;
                    R_BX:    BX <= reg_val;
                    R_SP:    SP <= reg_val;
                    R_BP:    BP <= reg_val;
                    R_SI:    SI <= reg_val;
                    default: DI <= reg_val;
                endcase
            end
            // INC/DEC leave CF alone; only ADD writes it.
            if (flags_we) begin
                F[FLAG_ZF] <= alu_zf;
                F[FLAG_SF] <= alu_sf;
                F[FLAG_OF] <= alu_of;
                if (opcode == OP_ADD_AX)
                    F[FLAG_CF] <= alu_cf;
            end
        end
    end

`ifdef Z8086_DBG_EN
    logic bus_pending;
    logic first_seen;
    logic first_now;

    assign first_now = !first_seen &&
                       ((state == ST_EXEC && !is_write_op) ||
                        (state == ST_BUS_WR && bus_pending && ready && !wr));

    always_ff @(posedge clk) begin
        if (reset_n) begin
            bus_pending    <= 1'b0;
            first_seen     <= 1'b0;
            dbg_first_done <= 1'b0;
        end else begin
            bus_pending    <= issue_rd || issue_wr || (bus_pending && !accept);
            first_seen     <= first_seen || exec_done;
            dbg_first_done <= first_now;
        end
    end
`else
    logic unused_exec_done;
    assign unused_exec_done = exec_done;
`endif

endmodule

// File: tb/tb_z8086_cpu.sv
// Scoreboard bench for z8086_cpu: directed programs at FFFF0, expected bus traffic queued.
module tb_z8086_cpu;

    localparam int W = 40;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [19:0] addr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        wr, rd, io, word;
    logic        ready;
    logic        intr = 1'b0;
    logic        nmi = 1'b0;
    logic        inta;
`ifdef Z8086_DBG_EN
    logic        dbg_first_done;
`endif

    z8086_cpu dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .addr           (addr),
        .din            (din),
        .dout           (dout),
        .wr             (wr),
        .rd             (rd),
        .io             (io),
        .word           (word),
        .ready          (ready),
        .intr           (intr),
        .nmi            (nmi),
`ifdef Z8086_DBG_EN
        .dbg_first_done (dbg_first_done),
`endif
        .inta           (inta)
    );

    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    logic [7:0]   mem[logic [19:0]];
    logic [7:0]   prog[$];
    int           checks = 0;
    int           errors = 0;

    function automatic logic [W-1:0] pack(input logic r, input logic w, input logic i,
                                          input logic wd, input logic [19:0] a,
                                          input logic [15:0] d);
        return {r, w, i, wd, a, d};
    endfunction

    function automatic logic [7:0] mem_rd(input logic [19:0] a);
        return mem.exists(a) ? mem[a] : 8'hF4;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every strobe is one transfer, compared against the head of the queue.
    initial begin : monitor
        logic [W-1:0] obs;
        forever begin
            @(negedge clk);
            if (rd === 1'b1 || wr === 1'b1) begin
                obs = pack(rd, wr, io, word, addr, wr ? dout : 16'h0000);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: got %h expected none", obs);
                end else begin
                    check("bus_xfer", obs, exp_q.pop_front());
                end
            end
        end
    end

    // Memory model: ready one to three cycles after the strobe.
    initial begin : mem_model
        logic [19:0] cap;
        int          lat;
        ready = 1'b0;
        din   = 16'h0000;
        forever begin
            @(negedge clk);
            ready = 1'b0;
            if (!reset_n && (rd || wr)) begin
                cap = addr;
                if (wr && !io) begin
                    mem[addr] = dout[7:0];
                    if (word) mem[addr + 20'd1] = dout[15:8];
                end
                lat = $urandom_range(3, 1);
                repeat (lat) @(negedge clk);
                if (!reset_n) check("addr_hold", W'(addr), W'(cap));
                din   = {mem_rd(cap + 20'd1), mem_rd(cap)};
                ready = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation did not finish");
    end

    task automatic start_test();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        mem.delete();
        exp_q.delete();
        check("rst_bus", pack(rd, wr, io, word, addr, dout), '0);
        check("rst_ip", W'(dut.IP), W'(16'hFFF0));
        check("rst_cs", W'(dut.CS), W'(16'hF000));
        check("rst_f", W'(dut.F), W'(16'h0002));
        check("rst_ax", W'(dut.AX), W'(16'h0000));
        check("rst_run", W'(dut.not_halted), W'(1'b1));
    endtask

    task automatic load_prog();
        for (int i = 0; i < prog.size(); i++)
            mem[20'hFFFF0 + 20'(i)] = prog[i];
    endtask

    task automatic push_reads(input int from, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 1'b0, 20'hFFFF0 + 20'(from + i), 16'h0000));
    endtask

    task automatic wait_halt(input string name);
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            if (dut.not_halted === 1'b0) break;
        end
        check({name, "_halted"}, W'(dut.not_halted), W'(1'b0));
        repeat (12) @(posedge clk);
        #1;
        check({name, "_drained"}, W'(exp_q.size()), W'(0));
    endtask

    task automatic wait_drain(input int budget);
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        check("drain", W'(exp_q.size()), W'(0));
    endtask

    task automatic run_simple(input string name, input logic [15:0] eax, input logic [15:0] ef);
        start_test();
        load_prog();
        push_reads(0, prog.size());
        reset_n = 1'b0;
        wait_halt(name);
        check({name, "_ax"}, W'(dut.AX), W'(eax));
        check({name, "_f"}, W'(dut.F), W'(ef));
        check({name, "_ip"}, W'(dut.IP), W'(16'hFFF0 + 16'(prog.size())));
    endtask

    initial begin : driver
        // MOV AX,1234; HLT
        prog = '{8'hB8, 8'h34, 8'h12, 8'hF4};
        run_simple("mov_hlt", 16'h1234, 16'h0002);

        // MOV AX,7FFF; ADD AX,0001 -> signed overflow into 8000
        prog = '{8'hB8, 8'hFF, 8'h7F, 8'h05, 8'h01, 8'h00, 8'hF4};
        run_simple("add_of", 16'h8000, 16'h0882);

        // MOV AX,FFFF; ADD AX,0001 -> wraps to 0 with carry
        prog = '{8'hB8, 8'hFF, 8'hFF, 8'h05, 8'h01, 8'h00, 8'hF4};
        run_simple("add_cf", 16'h0000, 16'h0043);

        // MOV AX,FFFF; INC AX -> 0, ZF set, CF untouched
        prog = '{8'hB8, 8'hFF, 8'hFF, 8'h40, 8'hF4};
        run_simple("inc_z", 16'h0000, 16'h0042);

        // INC AX then DEC AX back to FFFF
        prog = '{8'hB8, 8'hFF, 8'hFF, 8'h40, 8'h48, 8'hF4};
        run_simple("inc_dec", 16'hFFFF, 16'h0082);

        // Carry from ADD must survive a following INC
        prog = '{8'hB8, 8'hFF, 8'hFF, 8'h05, 8'h01, 8'h00, 8'hB8, 8'hFF, 8'hFF, 8'h40, 8'hF4};
        run_simple("inc_keeps_cf", 16'h0000, 16'h0043);

        // MOV AX,8000; DEC AX -> 7FFF with OF
        prog = '{8'hB8, 8'h00, 8'h80, 8'h48, 8'hF4};
        run_simple("dec_of", 16'h7FFF, 16'h0802);

        // Byte moves, MOV CX, NOP, unknown opcode, INC DI
        prog = '{8'hB0, 8'h11, 8'hB4, 8'h22, 8'hB3, 8'h33, 8'hB7, 8'h44,
                 8'hB9, 8'hCD, 8'hAB, 8'h90, 8'h0F, 8'h47, 8'hF4};
        run_simple("misc", 16'h2211, 16'h0002);
        check("misc_bx", W'(dut.BX), W'(16'h4433));
        check("misc_cx", W'(dut.CX), W'(16'hABCD));
        check("misc_di", W'(dut.DI), W'(16'h0001));

        // MOV AX,BEEF; MOV [0200],AX; HLT
        start_test();
        prog = '{8'hB8, 8'hEF, 8'hBE, 8'hA3, 8'h00, 8'h02, 8'hF4};
        load_prog();
        push_reads(0, 6);
        exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 1'b1, 20'h00200, 16'hBEEF));
        push_reads(6, 1);
        reset_n = 1'b0;
        wait_halt("store");
        check("store_lo", W'(mem_rd(20'h00200)), W'(8'hEF));
        check("store_hi", W'(mem_rd(20'h00201)), W'(8'hBE));
        check("store_ip", W'(dut.IP), W'(16'hFFF7));

        // MOV AX,1234; OUT 00,AX; HLT
        start_test();
        prog = '{8'hB8, 8'h34, 8'h12, 8'hE7, 8'h00, 8'hF4};
        load_prog();
        push_reads(0, 5);
        exp_q.push_back(pack(1'b0, 1'b1, 1'b1, 1'b1, 20'h00000, 16'h1234));
        push_reads(5, 1);
        reset_n = 1'b0;
        wait_halt("out");
        check("out_ip", W'(dut.IP), W'(16'hFFF6));

        // JMP +1 skips the HLT at FFFF2
        start_test();
        prog = '{8'hEB, 8'h01, 8'hF4, 8'h90, 8'hF4};
        load_prog();
        push_reads(0, 2);
        push_reads(3, 2);
        reset_n = 1'b0;
        wait_halt("jmp_fwd");
        check("jmp_fwd_ip", W'(dut.IP), W'(16'hFFF5));

        // JMP $ loops in place; reset lands mid-read
        start_test();
        prog = '{8'hEB, 8'hFE};
        load_prog();
        for (int i = 0; i < 4; i++) push_reads(0, 2);
        push_reads(0, 1);
        reset_n = 1'b0;
        wait_drain(300);
        check("loop_ip", W'(dut.IP), W'(16'hFFF0));
        reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("midrd_rst_bus", pack(rd, wr, io, word, addr, dout), '0);
        check("midrd_rst_ip", W'(dut.IP), W'(16'hFFF0));
        push_reads(0, 2);
        push_reads(0, 1);
        reset_n = 1'b0;
        wait_drain(100);
        check("loop2_ip", W'(dut.IP), W'(16'hFFF0));
        reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("final_rst_run", W'(dut.not_halted), W'(1'b1));
        check("inta_low", W'(inta), W'(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/z8086_cpu.md
Name: z8086_cpu

Overview:
- Minimal 8086-subset CPU core with a simplified single-master bus.
- Fetches instruction bytes one at a time from CS:IP and executes a small opcode subset.
- Supports one memory store and one I/O store instruction, and halts on HLT.
- Sits between the test harness and a 1 MB byte-addressable memory model with variable read latency.

Parameters:
- RESET_CS, 16'hF000, CS value loaded on reset.
- RESET_IP, 16'hFFF0, IP value loaded on reset (first fetch at physical 0xFFFF0).

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  reset; synchronous, active-high (core is in reset while reset_n=1 at a clk edge).
- addr  out  20  physical bus address.
- din  in  16  read data; byte at addr is din[7:0].
- dout  out  16  write data.
- wr  out  1  one-cycle write strobe.
- rd  out  1  one-cycle read strobe.
- io  out  1  1 = I/O space, qualifies rd/wr.
- word  out  1  1 = 16-bit transfer, 0 = byte.
- ready  in  1  transfer-complete pulse.
- intr  in  1  maskable interrupt request; ignored.
- nmi  in  1  NMI request; ignored.
- inta  out  1  interrupt acknowledge; constant 0.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Registers:
  - AX, CX, DX, BX, SP, BP, SI, DI, CS, DS, ES, SS, IP, F (16-bit each), named exactly so for hierarchical access.
  - not_halted (1 = running).
- Reset:
  - CS=RESET_CS, IP=RESET_IP, F=16'h0002, all other registers 0, not_halted=1.
  - FSM goes to FETCH.
  - Bus outputs: rd=wr=io=word=0, addr=0, dout=0.
  - Reset mid-transfer abandons the transfer; a late ready is ignored.
- Physical address = ({seg,4'b0} + off) mod 2^20. IP and offsets wrap at 16 bits.
- Bus rules:
  - Exactly one transfer outstanding at a time.
  - rd or wr is high for exactly one cycle.
  - addr, io, word and dout are held stable until ready.
  - ready arriving in the same cycle as the strobe is illegal; the earliest accepted ready is one cycle after the strobe.
- Fetch:
  - Byte read (word=0, io=0) at CS:IP. On ready, latch din[7:0] and IP += 1.
  - Immediates are fetched the same way, low byte first.
- FSM: FETCH_OP -> FETCH_IMM (0-2 bytes) -> EXEC -> [BUS_WR] -> FETCH_OP. HALT is absorbing until reset.
- Opcodes:
  - 90 NOP.
  - F4 HLT: not_halted=0, no further bus activity.
  - B0-B7 MOV r8,imm8: AL,CL,DL,BL,AH,CH,DH,BH.
  - B8-BF MOV r16,imm16: AX,CX,DX,BX,SP,BP,SI,DI.
  - 40-47 INC r16; 48-4F DEC r16.
  - 05 ADD AX,imm16.
  - EB JMP rel8: IP = IP_after_instruction + sign-extended imm.
  - A3 MOV [imm16],AX: word memory write at DS:imm16.
  - E7 OUT imm8,AX: word I/O write, addr = zero-extended imm8.
  - Any other opcode executes as a 1-byte NOP.
- Flags:
  - Bits used: CF bit0, ZF bit6, SF bit7, OF bit11; bit1 reads 1.
  - ADD updates CF/ZF/SF/OF.
  - INC/DEC update ZF/SF/OF and leave CF unchanged.
  - Overflow edges: 7FFF+1 sets OF; 8000-1 sets OF; FFFF+1 gives 0000 with ZF=1, CF=1 (ADD).
- Write completion: execution resumes the cycle after ready.

Optional Feature:
- Macro Z8086_DBG_EN.
- When defined:
  - Adds output dbg_first_done, a one-cycle pulse when the first instruction after reset finishes EXEC (including its write completing).
  - Adds internal debug register bus_pending (transfer outstanding).
- When undefined: neither exists.
- Architectural behaviour is identical in both builds.

Decomposition:
- Package z8086_pkg:
  - FSM state enum.
  - Opcode constants.
  - Flag bit indices.
  - Register-index typedef.
  - Function phys_addr(seg, off).
- One natural sub-module: z8086_alu (16-bit add/inc/dec with flag outputs). Decode and FSM stay in the top.

Test Plan:
- Reset, memory FFFF0: B8 34 12 F4 -> AX=0x1234, IP=0xFFF4, halted; exactly 4 byte reads at FFFF0..FFFF3.
- MOV AX,1234 then OUT 00,AX -> one io write with addr=0, dout=0x1234, word=1.
- MOV AX,7FFF; ADD AX,0001 -> AX=0x8000, OF=1, SF=1, ZF=0, CF=0.
- MOV AX,FFFF; INC AX -> AX=0, ZF=1, CF unchanged; then DEC AX -> AX=0xFFFF, SF=1.
- DS=0 (reset), MOV AX,BEEF; MOV [0200],AX -> mem[0x200]=EF, mem[0x201]=BE.
- JMP rel8 0xFE -> infinite self-loop (IP stays); repeat with reset asserted mid-read -> next fetch at FFFF0.
